load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/lsu_lane_align.sv | 51 +++++
 rtl/load_store_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access size encodings, FSM states, byte-lane masks.
// Pure declarations; no logic or timing of its own.
// Imported by the LSU top, its lane aligner and anything that decodes req_size.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [3:0] LANE_BYTE    = 4'b0001;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_WORD    = 4'b1111;

    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the LSU.
// No logic or latency; slave = LSU view, master = core view, mem = memory view.
// Request/response use valid-ready; the memory port has no backpressure.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_daddr;
    logic [31:0]       mem_indata;
    logic [31:0]       mem_outdata;

    modport slave (
        input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_outdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_daddr, mem_indata
    );

    modport master (
        output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport mem (
        input  mem_we, mem_daddr, mem_indata,
        output mem_outdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Store byte-lane mask/replication and load byte/half extraction with extension.
// Purely combinational, zero latency; no handshake.
// Expects naturally aligned addresses; misaligned ones are filtered upstream.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we_mask,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    always_comb begin
        we_mask   = LANE_WORD;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (size)
            SZ_BYTE: begin
                we_mask   = LANE_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                we_mask   = addr_lo[1] ? LANE_HALF_HI : LANE_HALF_LO;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; LSU_MISALIGN_CHECK_EN enables misalign errors.
// Accept->resp_valid: load 3 cycles, store 2, error 1.
// req_ready only in IDLE; response held until resp_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);

    state_e            state_q, state_d;
    logic              store_q, store_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept;
    logic              req_err;
    size_e             req_size_raw;
    size_e             req_size_eff;
    logic [ADDR_W-1:0] req_addr_eff;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    assign req_size_raw = size_e'(bus.req_size);
    assign accept       = bus.req_valid && bus.req_ready;

    // Without the check, misalignment is resolved by rounding the address down.
    always_comb begin
        req_size_eff = req_size_raw;
        req_addr_eff = bus.req_addr;
        req_err      = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        req_err = is_misaligned(req_size_raw, bus.req_addr[1:0]);
`else
        if (req_size_raw == SZ_ILL) req_size_eff = SZ_WORD;
        if (req_size_eff == SZ_HALF) req_addr_eff[0] = 1'b0;
        if (req_size_eff == SZ_WORD) req_addr_eff[1:0] = 2'b00;
`endif
    end

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (bus.mem_outdata),
        .we_mask     (lane_we),
        .wdata_rep   (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = store_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.resp_valid = (state_q == RESP);
        bus.mem_we     = (state_q == ACCESS && store_q) ? lane_we : 4'b0000;
    end

    // Request fields only move on accept, which keeps mem_daddr stable through RESP.
    always_comb begin
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            store_d = bus.req_store;
            size_d  = req_size_eff;
            uns_d   = bus.req_unsigned;
            addr_d  = req_addr_eff;
            wdata_d = bus.req_wdata;
            rdata_d = '0;
            err_d   = req_err;
        end
        if (state_q == WAIT) rdata_d = lane_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_q <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_daddr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_indata = lane_wdata;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
